// File: rtl/mem_addr_seq_if.sv
// Bus bundle: control request, dual-rail mux drive/observe, captured address to memory side.
// Latency: none, wires only.
// Backpressure: none; the master side paces the mux through the DATA/NULL handshake.
interface mem_addr_seq_if #(
  parameter int ADDR_W = 4
);
  // Control unit request
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] operand;

  // Dual-rail drive towards the address mux
  logic              ph0_t;
  logic              ph0_f;
  logic [ADDR_W-1:0] pc_t;
  logic [ADDR_W-1:0] pc_f;
  logic [ADDR_W-1:0] i_t;
  logic [ADDR_W-1:0] i_f;

  // Dual-rail mux outputs
  logic [ADDR_W-1:0] a_t;
  logic [ADDR_W-1:0] a_f;

  // Memory-side result and status
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_phase;
  logic              busy;
  logic              done;
  logic              err;

  // Sequencer side
  modport master (
    input  start, pc, operand, a_t, a_f,
    output ph0_t, ph0_f, pc_t, pc_f, i_t, i_f,
           addr, addr_valid, addr_phase, busy, done, err
  );

  // Environment side (control unit, mux, memory)
  modport slave (
    output start, pc, operand, a_t, a_f,
    input  ph0_t, ph0_f, pc_t, pc_f, i_t, i_f,
           addr, addr_valid, addr_phase, busy, done, err
  );
endinterface

// File: rtl/mem_addr_seq.sv
// Sequences the dual-rail address mux through fetch (PC) then operand (I) DATA/NULL phases.
// Latency: start->done is 9 cycles minimum; every wait state needs two agreeing rail samples.
// Backpressure: start is only taken in IDLE and never queued. Optional MEM_ADDR_SEQ_TIMEOUT_EN
// bounds every wait state to TIMEOUT cycles.
module mem_addr_seq #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst,
  mem_addr_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_DATA = 3'd1,
    F_NULL = 3'd2,
    O_DATA = 3'd3,
    O_NULL = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] op_q, op_d;

  logic              ph0_t_q, ph0_t_d;
  logic              ph0_f_q, ph0_f_d;
  logic [ADDR_W-1:0] pc_t_q, pc_t_d;
  logic [ADDR_W-1:0] pc_f_q, pc_f_d;
  logic [ADDR_W-1:0] i_t_q, i_t_d;
  logic [ADDR_W-1:0] i_f_q, i_f_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              addr_phase_q, addr_phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Previous-sample memory for two-sample qualification
  logic              comp_seen_q, comp_seen_d;
  logic              null_seen_q, null_seen_d;
  logic              ill_seen_q, ill_seen_d;

  logic              a_complete, a_null, a_illegal;
  logic              comp_ok, null_ok, ill_ok;
  logic              timed_out;
  logic              drive_data;

  assign a_complete = &(bus.a_t ^ bus.a_f);
  assign a_null     = ~|(bus.a_t | bus.a_f);
  assign a_illegal  = |(bus.a_t & bus.a_f);

  // A condition counts only when it held on the previous sample as well
  assign comp_ok = a_complete & comp_seen_q;
  assign null_ok = a_null & null_seen_q;
  assign ill_ok  = a_illegal & ill_seen_q;

`ifdef MEM_ADDR_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Per-state dwell counter, cleared whenever the state changes
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Dwell counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next state, operand capture and the address/done pulses
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    op_d         = op_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    addr_phase_d = addr_phase_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = bus.pc;
          op_d    = bus.operand;
          state_d = F_DATA;
        end
      end
      F_DATA: begin
        if (ill_ok) begin
          state_d = ERROR;
        end else if (comp_ok) begin
          addr_d       = bus.a_t;
          addr_valid_d = 1'b1;
          addr_phase_d = 1'b0;
          state_d      = F_NULL;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      F_NULL: begin
        if (ill_ok) begin
          state_d = ERROR;
        end else if (null_ok) begin
          state_d = O_DATA;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      O_DATA: begin
        if (ill_ok) begin
          state_d = ERROR;
        end else if (comp_ok) begin
          addr_d       = bus.a_t;
          addr_valid_d = 1'b1;
          addr_phase_d = 1'b1;
          state_d      = O_NULL;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      O_NULL: begin
        if (ill_ok) begin
          state_d = ERROR;
        end else if (null_ok) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Rail drive follows the state being entered, so NULL goes out on the same edge
  // the DATA phase completes; the IDLE->F_DATA edge only latches the operands
  always_comb begin
    drive_data = (state_q != IDLE) && ((state_d == F_DATA) || (state_d == O_DATA));
    ph0_t_d    = drive_data && (state_d == F_DATA);
    ph0_f_d    = drive_data && (state_d == O_DATA);
    pc_t_d     = drive_data ? pc_q  : '0;
    pc_f_d     = drive_data ? ~pc_q : '0;
    i_t_d      = drive_data ? op_q  : '0;
    i_f_d      = drive_data ? ~op_q : '0;
    busy_d     = (state_d != IDLE);
    err_d      = (state_d == ERROR);
  end

  // Sample history restarts on state entry so a stale sample never qualifies
  always_comb begin
    comp_seen_d = a_complete && (state_d == state_q);
    null_seen_d = a_null && (state_d == state_q);
    ill_seen_d  = a_illegal;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      op_q         <= '0;
      ph0_t_q      <= 1'b0;
      ph0_f_q      <= 1'b0;
      pc_t_q       <= '0;
      pc_f_q       <= '0;
      i_t_q        <= '0;
      i_f_q        <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_phase_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      comp_seen_q  <= 1'b0;
      null_seen_q  <= 1'b0;
      ill_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_q         <= op_d;
      ph0_t_q      <= ph0_t_d;
      ph0_f_q      <= ph0_f_d;
      pc_t_q       <= pc_t_d;
      pc_f_q       <= pc_f_d;
      i_t_q        <= i_t_d;
      i_f_q        <= i_f_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_phase_q <= addr_phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      comp_seen_q  <= comp_seen_d;
      null_seen_q  <= null_seen_d;
      ill_seen_q   <= ill_seen_d;
    end
  end

  assign bus.ph0_t      = ph0_t_q;
  assign bus.ph0_f      = ph0_f_q;
  assign bus.pc_t       = pc_t_q;
  assign bus.pc_f       = pc_f_q;
  assign bus.i_t        = i_t_q;
  assign bus.i_f        = i_f_q;
  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.addr_phase = addr_phase_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: hysteretic dual-rail mux model with programmable response delay,
// event monitor, and directed plus randomized sequences checked against the expected
// address/phase/cycle pattern of each transaction.
module tb_mem_addr_seq;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_addr_seq_if #(.ADDR_W(AW)) bus ();

  mem_addr_seq #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hysteretic mux: resolves once inputs are all-DATA (or all-NULL) for mux_dly extra cycles,
  // otherwise holds its outputs. ovr_* lets a step force arbitrary a rails.
  int            mux_dly   = 0;
  int            stab      = 0;
  int            last_kind = 0;
  logic [AW-1:0] mux_t = '0, mux_f = '0;
  logic          ovr_en = 1'b0;
  logic [AW-1:0] ovr_t = '0, ovr_f = '0;

  always @(negedge clk) begin : mux_model
    int            kind;
    logic [AW-1:0] sel;
    kind = 0;
    if (!(bus.ph0_t | bus.ph0_f) && !(|{bus.pc_t, bus.pc_f, bus.i_t, bus.i_f}))
      kind = 1;
    else if ((bus.ph0_t ^ bus.ph0_f) && (&(bus.pc_t ^ bus.pc_f)) && (&(bus.i_t ^ bus.i_f)))
      kind = 2;
    stab      = (kind == last_kind) ? stab + 1 : 1;
    last_kind = kind;
    sel       = bus.ph0_t ? bus.pc_t : bus.i_t;
    if (kind == 1 && stab > mux_dly) begin
      mux_t <= '0;
      mux_f <= '0;
    end else if (kind == 2 && stab > mux_dly) begin
      mux_t <= sel;
      mux_f <= ~sel;
    end
  end

  assign bus.a_t = ovr_en ? ovr_t : mux_t;
  assign bus.a_f = ovr_en ? ovr_f : mux_f;

  typedef struct {
    int            c;
    bit            is_done;
    logic [AW-1:0] a;
    logic          ph;
  } ev_t;

  ev_t evq[$];

  always @(negedge clk) begin
    if (bus.addr_valid === 1'b1)
      evq.push_back('{c: cyc, is_done: 1'b0, a: bus.addr, ph: bus.addr_phase});
    if (bus.done === 1'b1)
      evq.push_back('{c: cyc, is_done: 1'b1, a: '0, ph: 1'b0});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit done_seen();
    if (evq.size() == 0) return 1'b0;
    return evq[$].is_done;
  endfunction

  function automatic logic [31:0] rails();
    return 32'({bus.ph0_t, bus.ph0_f, bus.pc_t, bus.pc_f, bus.i_t, bus.i_f});
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rails"}, rails(), 0);
    check({tag, "_outs"}, 32'({bus.addr, bus.addr_valid, bus.addr_phase, bus.busy, bus.done, bus.err}), 0);
  endtask

  // One full transaction; inj >= 0 pulses a second start (pc=F) inj cycles after acceptance.
  // Expected timing: 1 latch cycle + four wait states of (2 samples + mux delay).
  task automatic run_txn(input logic [AW-1:0] p, input logic [AW-1:0] o, input int d, input int inj);
    int acc;
    int n;
    mux_dly = d;
    evq.delete();
    bus.pc      = p;
    bus.operand = o;
    bus.start   = 1'b1;
    acc = cyc + 1;
    tick();
    bus.start   = 1'b0;
    bus.pc      = AW'($urandom);
    bus.operand = AW'($urandom);
    check("busy_on_accept", bus.busy, 1);
    check("done_low_at_accept", bus.done, 0);
    check("rails_null_at_accept", rails(), 0);
    n = 0;
    while (!done_seen() && n < 200) begin
      tick();
      n++;
      if (cyc == acc + 1)
        check("fetch_rails", rails(), 32'({2'b10, p, ~p, o, ~o}));
      bus.start = (cyc == acc + inj);
      if (bus.start) begin
        bus.pc      = '1;
        bus.operand = '0;
      end
    end
    bus.start = 1'b0;
    check("txn_finished", n < 200, 1);
    check("txn_events", evq.size(), 3);
    if (evq.size() == 3) begin
      check("fetch_cyc", evq[0].c, acc + 3 + d);
      check("fetch_addr", {evq[0].is_done, evq[0].ph, evq[0].a}, {2'b00, p});
      check("oper_cyc", evq[1].c, acc + 7 + 3 * d);
      check("oper_addr", {evq[1].is_done, evq[1].ph, evq[1].a}, {2'b01, o});
      check("done_cyc", evq[2].c, acc + 9 + 4 * d);
      check("done_kind", evq[2].is_done, 1);
    end
    check("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pc      = '0;
    bus.operand = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Nominal sequence, then back-to-back randomized transactions with random mux delay
    run_txn(4'hA, 4'h3, 0, -1);
    for (int k = 0; k < 6; k++)
      run_txn(AW'($urandom), AW'($urandom), int'($urandom_range(0, 3)), -1);

    // Slow, glitchy completion: false complete at cycle 2, real one from cycle 5
    evq.delete();
    mux_dly = 0;
    ovr_en  = 1'b1;
    ovr_t   = '0;
    ovr_f   = '0;
    bus.pc = 4'hB; bus.operand = 4'h4; bus.start = 1'b1;
    acc = cyc + 1;
    tick();
    bus.start = 1'b0;
    while (cyc < acc + 12) begin
      tick();
      if (cyc == acc + 2 || cyc == acc + 5) begin
        ovr_t = 4'hB;
        ovr_f = ~4'hB;
      end else if (cyc == acc + 3) begin
        ovr_t = '0;
        ovr_f = '0;
      end
    end
    ovr_en = 1'b0;
    n = 0;
    while (!done_seen() && n < 200) begin
      tick();
      n++;
    end
    check("glitch_finished", n < 200, 1);
    check("glitch_events", evq.size(), 3);
    if (evq.size() == 3) begin
      check("glitch_fetch_cyc", evq[0].c, acc + 7);
      check("glitch_fetch_addr", {evq[0].ph, evq[0].a}, {1'b0, 4'hB});
      check("glitch_oper_addr", {evq[1].ph, evq[1].a}, {1'b1, 4'h4});
    end
    tick();

    // start while busy: ignored, not queued
    run_txn(4'h6, 4'h9, 0, 5);
    repeat (12) tick();
    check("inj_not_queued", evq.size(), 3);
    check("inj_idle", bus.busy, 0);

    // Illegal rail during O_DATA
    evq.delete();
    mux_dly = 0;
    bus.pc = 4'h2; bus.operand = 4'h5; bus.start = 1'b1;
    acc = cyc + 1;
    tick();
    bus.start = 1'b0;
    while (cyc < acc + 5) tick();
    check("ill_in_odata", {bus.ph0_t, bus.ph0_f}, 2'b01);
    ovr_en = 1'b1;
    ovr_t  = 4'b0010;
    ovr_f  = 4'b0010;
    tick();
    tick();
    ovr_en = 1'b0;
    repeat (10) tick();
    check("ill_err", {bus.err, bus.busy}, 2'b11);
    check("ill_rails", rails(), 0);
    check("ill_events", evq.size(), 1);
    check("ill_no_done", done_seen(), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("ill_rst");
    tick();

    // Wait-state bound with a stuck-null mux
    evq.delete();
    ovr_en = 1'b1;
    ovr_t  = '0;
    ovr_f  = '0;
    bus.pc = 4'h9; bus.operand = 4'h6; bus.start = 1'b1;
    acc = cyc + 1;
    tick();
    bus.start = 1'b0;
`ifdef MEM_ADDR_SEQ_TIMEOUT_EN
    while (cyc < acc + 7) tick();
    check("to_not_yet", bus.err, 0);
    tick();
    check("to_err", {bus.err, bus.busy}, 2'b11);
    check("to_rails", rails(), 0);
`else
    repeat (100) tick();
    check("no_to_err", bus.err, 0);
    check("no_to_busy", bus.busy, 1);
    check("no_to_fdata", {bus.ph0_t, bus.ph0_f}, 2'b10);
    check("no_to_events", evq.size(), 0);
`endif
    ovr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("to_rst");
    tick();

    // Reset during F_NULL, then a clean transaction
    evq.delete();
    mux_dly = 0;
    bus.pc = 4'h7; bus.operand = 4'h1; bus.start = 1'b1;
    acc = cyc + 1;
    tick();
    bus.start = 1'b0;
    while (cyc < acc + 3) tick();
    check("pre_rst_fetch", {bus.addr_valid, bus.addr}, {1'b1, 4'h7});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    run_txn(4'h5, 4'hC, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_addr_seq.md
# mem_addr_seq

Synchronous sequencer for the dual-rail memory-address mux. It takes a single-rail program counter and instruction operand, then drives the mux's dual-rail PH0/PC/I inputs through a four-phase DATA→NULL protocol: a fetch phase selecting PC, followed by an operand phase selecting I. It watches the mux's dual-rail A outputs for completion, captures each resolved address as a single-rail word, and signals it to the memory interface. It sits between the clocked control unit and the asynchronous, hysteretic address path.

## Interface
- ADDR_W, 4, address width; the mux has one dual-rail pair per bit.
- TIMEOUT, 64, maximum cycles allowed in any wait state (only with the timeout feature).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- pc  in  ADDR_W  program counter; latched when start is accepted.
- operand  in  ADDR_W  instruction address field; latched when start is accepted.
- ph0_t, ph0_f  out  1 each  dual-rail phase select; ph0_t=1 selects PC.
- pc_t, pc_f  out  ADDR_W each  dual-rail PC drive.
- i_t, i_f  out  ADDR_W each  dual-rail operand drive.
- a_t, a_f  in  ADDR_W each  dual-rail mux outputs.
- addr  out  ADDR_W  captured single-rail address.
- addr_valid  out  1  one-cycle pulse; addr is valid in the same cycle.
- addr_phase  out  1  0 = fetch address, 1 = operand address; qualified by addr_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence returns to IDLE.
- err  out  1  sticky error flag.

## Operation
- States: IDLE, F_DATA, F_NULL, O_DATA, O_NULL, ERROR. All outputs are registered.
- IDLE: all rails are 0. When start=1, latch pc and operand, then go to F_DATA.
- F_DATA:
  - Drive ph0_t=1 and ph0_f=0.
  - Drive pc_t=pc_q and pc_f=~pc_q; drive i_t=op_q and i_f=~op_q.
  - Wait for complete: every bit has a_t^a_f=1.
  - On complete: addr=a_t, addr_valid=1, addr_phase=0, then go to F_NULL.
- F_NULL: drive all rails to 0. Wait for null: a_t|a_f == 0. Then go to O_DATA.
- O_DATA:
  - Same as F_DATA, but ph0_t=0 and ph0_f=1.
  - On complete: addr_valid=1, addr_phase=1, then go to O_NULL.
- O_NULL: all rails are 0. Wait for null, then pulse done and go to IDLE.
- Settling: a completion or null condition is acted on only when it is true on two consecutive clk samples. A single-sample glitch restarts the qualification.
- Illegal rail:
  - Any bit with a_t & a_f = 1 on two consecutive samples, in any non-IDLE state, sends the block to ERROR.
  - In ERROR: err=1, all rails 0, busy=1. The block leaves ERROR only on rst.
- start while busy is ignored; it is not queued.
- Reset (including mid-sequence) forces IDLE on the next edge:
  - all rails 0
  - addr=0, addr_valid=0, addr_phase=0
  - busy=0, done=0, err=0
- The mux's hysteresis holds its outputs until all of its inputs are null. NULL states therefore drive every input rail to 0, never only PH0.

## Timing
- start accepted at edge N → rails show DATA after edge N+1.
- With ideal a rails that resolve within one cycle, addr_valid asserts no earlier than edge N+3.
- Minimum total sequence, start to done: 9 cycles. This is 1 (latch) + 4 wait states × 2-sample qualification.
- Back-to-back operation: start in the cycle after done is accepted.
- addr_valid and done are never asserted in the same cycle.

## Configuration
- MEM_ADDR_SEQ_TIMEOUT_EN defined:
  - A per-state cycle counter is cleared on every state entry.
  - If the counter reaches TIMEOUT in F_DATA, F_NULL, O_DATA or O_NULL, the block goes to ERROR with err=1.
- MEM_ADDR_SEQ_TIMEOUT_EN undefined:
  - There is no counter; wait states wait indefinitely.
  - err is raised only by an illegal rail.

## Test plan
- Nominal sequence: pc=4'hA, operand=4'h3, with a behavioural mux model responding in 1 cycle.
  - addr_valid with addr=4'hA and addr_phase=0, then addr_valid with addr=4'h3 and addr_phase=1.
  - done 9 cycles after start is accepted.
- Slow and glitchy completion: a rails complete after 5 cycles, with a 1-cycle false-complete pulse at cycle 2.
  - No addr_valid before cycle 5+2; addr is correct.
- Illegal rail: force a_t[1]=a_f[1]=1 for 2 cycles during O_DATA.
  - err=1, all rails 0, busy stays 1 until rst; no done.
- Timeout, with the macro defined and TIMEOUT=8: hold the a rails null in F_DATA.
  - ERROR after 8 cycles.
  - Without the macro: the block is still in F_DATA after 100 cycles, with err=0.
- Reset mid-sequence: assert rst during F_NULL.
  - Next cycle: every output at its reset value.
  - A following start with pc=4'h5, operand=4'hC completes normally.
- start while busy: pulse start again with pc=4'hF during O_DATA.
  - It is ignored; the second addr is still the original operand, and exactly one done is produced.
